palette_color_mapper: RTL
=========================

// Module: palette_color_mapper
// PURPOSE
//  Pipelined successor to the 1-bit fg/bg colour mapper in the HDMI text controller.
//  - fg/bg become palette indices into a run-time-writable RGB palette.
//  - Adds per-glyph invert, optional attribute blink and sync/valid alignment.
//  - Sits between the glyph/attribute fetch stage and the HDMI/VGA encoder.
// PARAMETERS
//  COLOR_W       4    bits per colour channel
//  PAL_DEPTH     16   palette entries
//  IDX_W         $clog2(PAL_DEPTH)  palette index width
//  BLINK_FRAMES  30   frames per blink half-period (>=1)
//  SYNC_W        3    sideband bits delayed with pixel (hsync, vsync, vde)
// PORTS
//  axi_aclk      in   1          single clock (pixel clock domain)
//  axi_aresetn   in   1          synchronous active-low reset
//  pix_valid     in   1          input pixel qualifier
//  pixel_data    in   1          glyph bit: 1=foreground, 0=background
//  invert        in   1          swap fg/bg for this pixel
//  blink         in   1          blink attribute for this pixel
//  fg_idx        in   IDX_W      foreground palette index
//  bg_idx        in   IDX_W      background palette index
//  sync_in       in   SYNC_W     sideband, delayed to match RGB
//  frame_start   in   1          one-cycle pulse per frame
//  pal_we        in   1          palette write strobe
//  pal_waddr     in   IDX_W      palette write address
//  pal_wdata     in   3*COLOR_W  {R,G,B}
//  red,green,blue out COLOR_W    registered RGB
//  sync_out      out  SYNC_W     sync_in delayed 2 cycles
//  pix_valid_out out  1          pix_valid delayed 2 cycles
// BEHAVIOUR
//  - Reset (axi_aresetn=0 at posedge): red/green/blue=0, sync_out=0,
//    pix_valid_out=0, both pipeline stages invalid, blink counter=0, blink_phase=0.
//  - Palette contents are NOT reset; pal_we is ignored while in reset.
//  - Reset asserted mid-stream flushes both pipeline stages. The first valid
//    output appears 2 cycles after the first valid input following release.
//  - Latency is fixed at 2 cycles. No backpressure; one pixel per clock.
//  - S1 (register): hide = blink & blink_phase; eff = (pixel_data & ~hide) ^ invert.
//    Register sel_idx = eff ? fg_idx : bg_idx, plus valid and sync.
//  - Blink therefore shows background, or foreground when inverted, during the hidden phase.
//  - S2 (register): RGB = palette[sel_idx] when valid, else 0 (blanking).
//    sync/valid advance every cycle regardless of valid.
//  - Palette write is synchronous: pal_we=1 writes pal_wdata at pal_waddr.
//  - Read/write collision on the same address in the same cycle: S2 reads the
//    OLD value. The new value is visible from the next cycle.
//  - If PAL_DEPTH is not a power of 2: writes with addr >= PAL_DEPTH are
//    dropped; reads with index >= PAL_DEPTH return 0.
//  - Blink counter: on frame_start, cnt = (cnt == BLINK_FRAMES-1) ? 0 : cnt+1.
//    blink_phase toggles on wrap. A frame_start during reset is ignored.
//  - Width rules: cnt width is $clog2(BLINK_FRAMES+1). No truncation of
//    pal_wdata fields: [3C-1:2C]=R, [2C-1:C]=G, [C-1:0]=B.
// CONFIGURATION
//  Macro PALETTE_COLOR_MAPPER_BLINK_EN.
//  - Defined: blink counter, blink_phase and hide logic are present as above.
//  - Undefined: hide is constant 0. blink and frame_start are accepted and
//    ignored. No counter registers. Latency and all other behaviour unchanged.
// STRUCTURE
//  - Package color_mapper_pkg: rgb_t packed struct {r,g,b} of COLOR_W; default
//    COLOR_W/PAL_DEPTH localparams; helper function rgb_unpack(wdata).
//  - Sub-module palette_ram: PAL_DEPTH x rgb_t, 1 sync write port,
//    1 registered read port with old-data-on-collision semantics. S2 is its read register.
//  - Blink counter stays inline under the macro.
// TESTING
//  1. Reset mid-stream: drive valid pixels, pull axi_aresetn low 1 cycle ->
//     next 2 outputs RGB=0 and pix_valid_out=0. Pixel accepted in the release
//     cycle is output 2 cycles later.
//  2. Palette map: write idx3=12'hF00, idx5=12'h0F0. Drive fg=3, bg=5:
//     pixel_data=1 -> RGB F,0,0 at +2; pixel_data=0 -> 0,F,0. invert=1 swaps both.
//  3. Collision: idx3=12'hF00, same cycle write idx3=12'h00F while S2 reads 3
//     -> output F00; next pixel -> 00F.
//  4. Blink (BLINK_EN, BLINK_FRAMES=2): blink=1, pixel_data=1, fg=3, bg=5.
//     Frames 0-1 show fg, frames 2-3 show bg, frame 4 shows fg.
//     With invert=1 the pattern is reversed.
//  5. Blanking/sync: pix_valid=0 with sync_in=3'b101 -> RGB=0,
//     sync_out=3'b101, pix_valid_out=0 exactly 2 cycles later.
//  6. Macro undefined: repeat test 4 -> fg shown in every frame.

Source files
------------

// File: rtl/palette_color_mapper_pkg.sv
// Shared types for the palette colour mapper: RGB pixel struct and
// default sizing, plus the packed {R,G,B} write-word unpacker.
package color_mapper_pkg;

    localparam int CM_COLOR_W   = 4;
    localparam int CM_PAL_DEPTH = 16;

    typedef struct packed {
        logic [CM_COLOR_W-1:0] r;
        logic [CM_COLOR_W-1:0] g;
        logic [CM_COLOR_W-1:0] b;
    } rgb_t;

    function automatic rgb_t rgb_unpack(input logic [3*CM_COLOR_W-1:0] wdata);
        rgb_t v;
        v.r = wdata[3*CM_COLOR_W-1:2*CM_COLOR_W];
        v.g = wdata[2*CM_COLOR_W-1:CM_COLOR_W];
        v.b = wdata[CM_COLOR_W-1:0];
        return v;
    endfunction

endpackage

// File: rtl/palette_color_mapper_palette_ram.sv
// Palette store: one synchronous write port and one registered read port
// that returns the pre-write word when both hit the same address.
module palette_ram
    import color_mapper_pkg::*;
#(
    parameter int DEPTH = CM_PAL_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  rgb_t          wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output rgb_t          rdata
);

    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

    rgb_t r_mem [DEPTH];
    rgb_t r_rdata;
    logic w_wr_ok;
    logic w_rd_ok;

    assign w_wr_ok = we & ({1'b0, waddr} < LIMIT);
    assign w_rd_ok = re & ({1'b0, raddr} < LIMIT);

    // Contents are deliberately not reset; writes are held off in reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_ok) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_rd_ok) begin
            r_rdata <= r_mem[raddr];
        end else begin
            r_rdata <= '0;
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/palette_color_mapper.sv
// Two-stage glyph-to-RGB palette mapper with invert and sideband alignment.
// Attribute blink is built only when PALETTE_COLOR_MAPPER_BLINK_EN is defined.
module palette_color_mapper
    import color_mapper_pkg::*;
#(
    parameter int COLOR_W      = CM_COLOR_W,
    parameter int PAL_DEPTH    = CM_PAL_DEPTH,
    parameter int IDX_W        = $clog2(PAL_DEPTH),
    parameter int BLINK_FRAMES = 30,
    parameter int SYNC_W       = 3
) (
    input  logic                 axi_aclk,
    input  logic                 axi_aresetn,
    input  logic                 pix_valid,
    input  logic                 pixel_data,
    input  logic                 invert,
    input  logic                 blink,
    input  logic [IDX_W-1:0]     fg_idx,
    input  logic [IDX_W-1:0]     bg_idx,
    input  logic [SYNC_W-1:0]    sync_in,
    input  logic                 frame_start,
    input  logic                 pal_we,
    input  logic [IDX_W-1:0]     pal_waddr,
    input  logic [3*COLOR_W-1:0] pal_wdata,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic [SYNC_W-1:0]    sync_out,
    output logic                 pix_valid_out
);

    logic              r_s1_valid;
    logic [IDX_W-1:0]  r_s1_idx;
    logic [SYNC_W-1:0] r_s1_sync;
    logic              r_s2_valid;
    logic [SYNC_W-1:0] r_s2_sync;
    logic              w_hide;
    logic              w_eff;
    rgb_t              w_wdata;
    rgb_t              w_rgb;

`ifdef PALETTE_COLOR_MAPPER_BLINK_EN
    localparam int CNT_W = $clog2(BLINK_FRAMES + 1);

    logic [CNT_W-1:0] r_blink_cnt;
    logic             r_blink_phase;
    logic             w_wrap;

    assign w_wrap = (r_blink_cnt == CNT_W'(BLINK_FRAMES - 1));

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (frame_start) begin
            r_blink_cnt <= w_wrap ? '0 : r_blink_cnt + 1'b1;
            if (w_wrap) begin
                r_blink_phase <= ~r_blink_phase;
            end
        end
    end

    assign w_hide = blink & r_blink_phase;
`else
    logic w_unused_blink;

    assign w_hide         = 1'b0;
    assign w_unused_blink = blink ^ frame_start ^ (BLINK_FRAMES > 0);
`endif

    // Hidden glyph bits fall back to background; invert then swaps roles.
    assign w_eff = (pixel_data & ~w_hide) ^ invert;

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
            r_s1_sync  <= '0;
        end else begin
            r_s1_valid <= pix_valid;
            r_s1_idx   <= w_eff ? fg_idx : bg_idx;
            r_s1_sync  <= sync_in;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            r_s2_valid <= 1'b0;
            r_s2_sync  <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_sync  <= r_s1_sync;
        end
    end

    assign w_wdata = rgb_unpack(pal_wdata);

    // The palette read register doubles as the S2 RGB register.
    palette_ram #(
        .DEPTH (PAL_DEPTH),
        .AW    (IDX_W)
    ) u_pal (
        .clk   (axi_aclk),
        .rst_n (axi_aresetn),
        .we    (pal_we),
        .waddr (pal_waddr),
        .wdata (w_wdata),
        .re    (r_s1_valid),
        .raddr (r_s1_idx),
        .rdata (w_rgb)
    );

    assign red           = w_rgb.r;
    assign green         = w_rgb.g;
    assign blue          = w_rgb.b;
    assign sync_out      = r_s2_sync;
    assign pix_valid_out = r_s2_valid;

endmodule
